// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix-multiply buffer controllers.
//   wb_state_e   : write-back engine state encoding
//   clog2_min1() : address/counter width helper, never returns less than 1
//   buf_addr_w() : per-bank address width of an M x M buffer split over N1 banks
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } wb_state_e;

  function automatic int clog2_min1(input int value);
    int w;
    w = (value > 1) ? $clog2(value) : 1;
    return w;
  endfunction

  function automatic int buf_addr_w(input int m, input int n1);
    return clog2_min1((m * m) / n1);
  endfunction

endpackage

// File: rtl/wb_tile_counter.sv
// Two-level result tile position counter.
//   clk_i    : clock
//   rst_i    : synchronous reset, active low
//   clr_i    : return both counters to zero
//   en_i     : advance one beat (col first, slice on col wrap)
//   col_o    : column within the current row slice, 0..M-1
//   slice_o  : row slice index, 0..M/N1-1
//   last_o   : current position is the final beat of the frame
module wb_tile_counter
  import systolic_pkg::*;
#(
  parameter int M       = 8,
  parameter int N1      = 4,
  parameter int COL_W   = clog2_min1(M),
  parameter int SLICE_W = clog2_min1(M / N1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [COL_W-1:0]   col_o,
  output logic [SLICE_W-1:0] slice_o,
  output logic               last_o
);

  localparam logic [COL_W-1:0]   COL_MAX   = COL_W'(M - 1);
  localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'((M / N1) - 1);

  logic [COL_W-1:0]   col_q, col_d;
  logic [SLICE_W-1:0] slice_q, slice_d;

  always_comb begin
    col_d   = col_q;
    slice_d = slice_q;
    if (clr_i) begin
      col_d   = '0;
      slice_d = '0;
    end else if (en_i) begin
      if (col_q == COL_MAX) begin
        col_d   = '0;
        // Slice wraps too, so the counters sit at zero after the final beat.
        slice_d = (slice_q == SLICE_MAX) ? '0 : slice_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      col_q   <= '0;
      slice_q <= '0;
    end else begin
      col_q   <= col_d;
      slice_q <= slice_d;
    end
  end

  assign col_o   = col_q;
  assign slice_o = slice_q;
  assign last_o  = (col_q == COL_MAX) && (slice_q == SLICE_MAX);

endmodule

// File: rtl/systolic_wb_writer.sv
// Result write-back engine: takes N1-word result beats from the array drain
// and writes them row-slice-major into the banked C buffer through one
// registered output stage.
//   clk_i      : clock
//   rst_i      : synchronous reset, active low
//   start_i    : pulse to begin a frame (honoured only when idle)
//   in_valid_i / in_ready_o / in_data_i : result beat stream
//   wr_valid_o / wr_ready_i / wr_addr_o / wr_data_o : buffer write port
//   busy_o     : frame in progress (RUN or DRAIN)
//   done_o     : one-cycle pulse after the final write is accepted
module systolic_wb_writer
  import systolic_pkg::*;
#(
  parameter  int N1     = 4,
  parameter  int N2     = 4,
  parameter  int M      = 8,
  parameter  int DW     = 16,
  localparam int ADDR_W = buf_addr_w(M, N1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N1*DW-1:0]     in_data_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [ADDR_W-1:0]    wr_addr_o,
  output logic [N1*DW-1:0]     wr_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int COL_W   = clog2_min1(M);
  localparam int SLICE_W = clog2_min1(M / N1);

  if (((M % N1) != 0) || ((M % N2) != 0) || (N1 > M)) begin : g_bad_params
    $error("systolic_wb_writer: M must be a multiple of N1 and N2, and N1 <= M");
  end

  wb_state_e state_q, state_d;

  logic                 wr_valid_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [N1*DW-1:0]     wr_data_q;

  logic [COL_W-1:0]     tile_col;
  logic [SLICE_W-1:0]   tile_slice;
  logic                 tile_last;
  logic                 cnt_clr;
  logic                 accept;
  logic [ADDR_W-1:0]    addr_now;

  assign accept   = in_valid_i && in_ready_o;
  assign addr_now = ADDR_W'(tile_slice) * ADDR_W'(M) + ADDR_W'(tile_col);

  wb_tile_counter #(
    .M       (M),
    .N1      (N1),
    .COL_W   (COL_W),
    .SLICE_W (SLICE_W)
  ) u_tile_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (accept),
    .col_o   (tile_col),
    .slice_o (tile_slice),
    .last_o  (tile_last)
  );

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    cnt_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
        end
      end
      S_RUN: begin
        busy_o     = 1'b1;
        // A beat may enter while the current write leaves in the same cycle.
        in_ready_o = !wr_valid_q || wr_ready_i;
        if (in_valid_i && in_ready_o && tile_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (wr_valid_q && wr_ready_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_valid_q <= 1'b1;
        wr_addr_q  <= addr_now;
        wr_data_q  <= in_data_i;
      end else if (wr_ready_i) begin
        wr_valid_q <= 1'b0;
      end
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: tb/tb_systolic_wb_writer.sv
module tb_systolic_wb_writer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance: N1=4, M=8, DW=16 -> 16 beats, 4-bit address
  logic        start = 1'b0, in_valid = 1'b0, wr_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_ready, wr_valid, busy, done;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;

  // Second instance: N1=2, M=8 -> 32 beats, 5-bit address
  logic        start2 = 1'b0, in_valid2 = 1'b0, wr_ready2 = 1'b1;
  logic [31:0] in_data2 = '0;
  logic        in_ready2, wr_valid2, busy2, done2;
  logic [4:0]  wr_addr2;
  logic [31:0] wr_data2;

  systolic_wb_writer #(.N1(4), .N2(4), .M(8), .DW(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .busy_o(busy), .done_o(done)
  );

  systolic_wb_writer #(.N1(2), .N2(4), .M(8), .DW(16)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2), .in_data_i(in_data2),
    .wr_valid_o(wr_valid2), .wr_ready_i(wr_ready2), .wr_addr_o(wr_addr2),
    .wr_data_o(wr_data2), .busy_o(busy2), .done_o(done2)
  );

  // Write/done logs
  int          wn = 0, dn = 0, wn2 = 0, dn2 = 0;
  logic [4:0]  wa  [128];
  logic [63:0] wd  [128];
  logic [4:0]  wa2 [64];

  always @(posedge clk) begin
    if (rst && wr_valid && wr_ready) begin
      if (wn < 128) begin
        wa[wn] <= 5'(wr_addr);
        wd[wn] <= wr_data;
      end
      wn <= wn + 1;
    end
    if (rst && done) dn <= dn + 1;
    if (rst && wr_valid2 && wr_ready2) begin
      if (wn2 < 64) wa2[wn2] <= wr_addr2;
      wn2 <= wn2 + 1;
    end
    if (rst && done2) dn2 <= dn2 + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Write log from index base must hold addresses 0..n-1 in order with data = beat index
  task automatic verify_seq(input string tag, input int base, input int n,
                            input int sp_idx, input logic [63:0] sp_val);
    logic [63:0] exp_d;
    chk({tag, "_count"}, 64'(wn - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      exp_d = (i == sp_idx) ? sp_val : 64'(i);
      chk({tag, "_addr"}, 64'(wa[base + i]), 64'(i));
      chk({tag, "_data"}, wd[base + i], exp_d);
    end
  endtask

  int   wb, db, wb2, db2, next_k;
  logic acc;
  bit   fin;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b0;
    tick();
    tick();
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_addr",  64'(wr_addr),  64'd0);
    chk("rst_wr_data",  wr_data,       64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst2_wr_valid", 64'(wr_valid2), 64'd0);
    rst = 1'b1;
    tick();

    // ---------------- 1: continuous frame ----------------
    wb = wn; db = dn;
    pulse_start();
    chk("t1_busy_after_start",  64'(busy),     64'd1);
    chk("t1_ready_after_start", 64'(in_ready), 64'd1);
    chk("t1_valid_after_start", 64'(wr_valid), 64'd0);
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(k);
      tick();
      chk("t1_wr_valid", 64'(wr_valid), 64'd1);
      chk("t1_wr_addr",  64'(wr_addr),  64'(k));
      chk("t1_wr_data",  wr_data,       64'(k));
    end
    chk("t1_drain_done", 64'(done), 64'd0);
    chk("t1_drain_busy", 64'(busy), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("t1_done_at_18", 64'(done), 64'd1);
    chk("t1_busy_low",   64'(busy), 64'd0);
    chk("t1_valid_low",  64'(wr_valid), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    tick();
    chk("t1_done_count", 64'(dn - db), 64'd1);
    verify_seq("t1", wb, 16, -1, 64'd0);

    // ---------------- 2: stall on beat 9 ----------------
    wb = wn;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = (k == 9) ? 64'hAAAA_BBBB_CCCC_DDDD : 64'(k);
      tick();
    end
    chk("t2_addr9", 64'(wr_addr), 64'd9);
    chk("t2_data9", wr_data, 64'hAAAA_BBBB_CCCC_DDDD);
    wr_ready = 1'b0;
    in_data  = 64'd10;
    #1;
    chk("t2_stall_ready", 64'(in_ready), 64'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t2_hold_valid", 64'(wr_valid), 64'd1);
      chk("t2_hold_addr",  64'(wr_addr),  64'd9);
      chk("t2_hold_data",  wr_data,       64'hAAAA_BBBB_CCCC_DDDD);
      chk("t2_hold_ready", 64'(in_ready), 64'd0);
    end
    wr_ready = 1'b1;
    for (int k = 10; k < 16; k++) begin
      in_data = 64'(k);
      tick();
      chk("t2_wr_addr", 64'(wr_addr), 64'(k));
    end
    in_valid = 1'b0;
    wait_done("t2_done_seen");
    tick();
    verify_seq("t2", wb, 16, 9, 64'hAAAA_BBBB_CCCC_DDDD);

    // ---------------- 3: random valid / ready ----------------
    wb = wn;
    pulse_start();
    next_k = 0;
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      wr_ready = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 64'(next_k);
      #1;
      acc = in_valid && in_ready;
      tick();
      if (acc) next_k++;
      if (done === 1'b1) fin = 1'b1;
    end
    wr_ready = 1'b1;
    in_valid = 1'b0;
    chk("t3_finished",   64'(fin),    64'd1);
    chk("t3_beats_took", 64'(next_k), 64'd16);
    tick();
    verify_seq("t3", wb, 16, -1, 64'd0);

    // ---------------- 4: stray start / in_valid ----------------
    wb = wn; db = dn;
    in_valid = 1'b1;
    in_data  = 64'h77;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t4_idle_ready", 64'(in_ready), 64'd0);
      chk("t4_idle_valid", 64'(wr_valid), 64'd0);
    end
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      in_data = 64'(k);
      start   = (k == 5);
      tick();
      chk("t4_wr_addr", 64'(wr_addr), 64'(k));
    end
    start   = 1'b0;
    in_data = 64'h99;
    tick();
    chk("t4_done", 64'(done), 64'd1);
    tick();
    tick();
    in_valid = 1'b0;
    chk("t4_idle_after", 64'(busy), 64'd0);
    chk("t4_no_extra_valid", 64'(wr_valid), 64'd0);
    chk("t4_done_count", 64'(dn - db), 64'd1);
    verify_seq("t4", wb, 16, -1, 64'd0);

    // ---------------- 5: reset mid-frame ----------------
    wb = wn;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(k);
      tick();
    end
    wr_ready = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    chk("t5_rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("t5_rst_wr_addr",  64'(wr_addr),  64'd0);
    chk("t5_rst_wr_data",  wr_data,       64'd0);
    chk("t5_rst_busy",     64'(busy),     64'd0);
    chk("t5_rst_done",     64'(done),     64'd0);
    chk("t5_rst_in_ready", 64'(in_ready), 64'd0);
    rst      = 1'b1;
    wr_ready = 1'b1;
    tick();
    chk("t5_still_idle", 64'(busy), 64'd0);
    verify_seq("t5_partial", wb, 7, -1, 64'd0);
    wb = wn;
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(k);
      tick();
      chk("t5_restart_addr", 64'(wr_addr), 64'(k));
    end
    in_valid = 1'b0;
    wait_done("t5_done_seen");
    tick();
    verify_seq("t5", wb, 16, -1, 64'd0);

    // ---------------- 6: N1=2 instance ----------------
    wb2 = wn2; db2 = dn2;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      in_valid2 = 1'b1;
      in_data2  = 32'(k);
      tick();
      chk("t6_wr_addr", 64'(wr_addr2), 64'(k));
    end
    chk("t6_final_addr", 64'(wr_addr2), 64'd31);
    chk("t6_drain_done", 64'(done2), 64'd0);
    in_valid2 = 1'b0;
    tick();
    chk("t6_done",       64'(done2), 64'd1);
    tick();
    chk("t6_done_pulse", 64'(done2), 64'd0);
    tick();
    chk("t6_done_count",  64'(dn2 - db2), 64'd1);
    chk("t6_write_count", 64'(wn2 - wb2), 64'd32);
    chk("t6_last_logged", 64'(wa2[wb2 + 31]), 64'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
